// File: rtl/serial_subtractor_4bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_4bit
//
// Bit-serial unsigned subtractor. On an accepted start the operands are
// captured into shift registers. One full-subtractor cell then processes one
// bit per clock, LSB first, for WIDTH cycles. The result is registered on the
// last RUN edge and flagged by a one-cycle done pulse.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; accepted only in IDLE
//   a      in   WIDTH  minuend    (captured on accept)
//   b      in   WIDTH  subtrahend (captured on accept)
//   bin    in   1      borrow-in  (captured on accept)
//   diff   out  WIDTH  a - b - bin mod 2^WIDTH, held until the next result
//   bout   out  1      borrow-out (a < b + bin), held until the next result
//   busy   out  1      high while bits are being processed (RUN)
//   done   out  1      one-cycle pulse: diff/bout just updated (DONE)
//
// Timing: start accepted at edge k -> busy after edges k..k+WIDTH-1,
// done for the cycle after edge k+WIDTH, back in IDLE after edge k+WIDTH+1.
// ---------------------------------------------------------------------------
module serial_subtractor_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  // The counter must be able to hold WIDTH without wrapping.
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] x_sr, y_sr, res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             x, y, d, br_nx;
  logic             last_bit;
  logic [WIDTH-1:0] res_nx;

  // -------------------------------------------------------------------------
  // Full-subtractor cell on the current operand LSBs and the borrow flop.
  // -------------------------------------------------------------------------
  always_comb begin
    x        = x_sr[0];
    y        = y_sr[0];
    d        = x ^ y ^ br;
    br_nx    = (~x & y) | (~(x ^ y) & br);
    // Each difference bit enters at the MSB, so after WIDTH shifts the first
    // (LSB) bit has walked down to position 0.
    res_nx   = {d, res_sr[WIDTH-1:1]};
    last_bit = (cnt == LAST);
  end

  // -------------------------------------------------------------------------
  // State register.
  // -------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every flop
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // -------------------------------------------------------------------------
  // Next-state and status decode.
  // -------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: operand capture, serial shift, result publication.
  // start seen in RUN or DONE falls through without touching the operands.
  // -------------------------------------------------------------------------
  // NOTE: the shift registers, borrow flop and counter are reset along with
  // the outputs; they are a handful of flops, not a RAM, so a reset is cheap
  // and keeps every internal value defined after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_sr   <= '0;
      y_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            x_sr   <= a;
            y_sr   <= b;
            br     <= bin;
            res_sr <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          x_sr   <= x_sr >> 1;
          y_sr   <= y_sr >> 1;
          br     <= br_nx;
          res_sr <= res_nx;
          cnt    <= cnt + CW'(1);
          // Outputs change only here, so they stay stable through RUN and
          // hold the previous result until this final bit.
          if (last_bit) begin
            diff <= res_nx;
            bout <= br_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_4bit
//
// Self-checking bench for serial_subtractor_4bit (WIDTH=4). Expected results
// come from plain integer arithmetic on a - b - bin; timing expectations come
// from the documented latency (done WIDTH cycles after acceptance, period
// WIDTH+2 with start held high).
// ---------------------------------------------------------------------------
module tb_serial_subtractor_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic [W-1:0] diff;
  logic         bout, busy, done;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  serial_subtractor_4bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: integer subtraction; borrow-out is simply "result negative".
  function automatic logic [W:0] model(input int aa, input int bb, input int bi);
    int           r;
    logic [W-1:0] dd;
    r  = aa - bb - bi;
    dd = r[W-1:0];
    return {(r < 0), dd};
  endfunction

  // Drives one request, scrambles the inputs right after acceptance and
  // observes W+3 cycles at the falling edge. done_at is the cycle index
  // (0 = first cycle after acceptance) of the first done pulse, -1 if none.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic obin,
                       output logic [W-1:0] rd, output logic rb,
                       output int done_at, output int done_cnt,
                       output int busy_cnt, output bit overlap,
                       output bit held);
    logic [W-1:0] d0;
    @(negedge clk);
    a = oa; b = ob; bin = obin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    d0 = diff;
    done_at = -1; done_cnt = 0; busy_cnt = 0; overlap = 0; held = 1;
    rd = '0; rb = 1'b0;
    for (int c = 0; c < W + 3; c++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (diff !== d0) held = 0;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c; rd = diff; rb = bout;
        end
      end
      if (busy && done) overlap = 1;
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1;
    n_cmp++;
    if ({diff, bout, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got diff=%0d bout=%b busy=%b done=%b, want all 0",
               diff, bout, busy, done);
    end
    // start is ignored while reset is held.
    start = 1'b1; a = 4'd9; b = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_start_ignored: got busy=%b done=%b, want 0 0", busy, done);
      end
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_directed();
    logic [W-1:0] va[4] = '{4'd9, 4'd3, 4'd0, 4'd15};
    logic [W-1:0] vb[4] = '{4'd3, 4'd9, 4'd0, 4'd15};
    logic         vi[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] ed[4] = '{4'd6, 4'd10, 4'd15, 4'd15};
    logic         eb[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] rd;
    logic         rb;
    int           dat, dcn, bcn;
    bit           ovl, hld;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vi[i], rd, rb, dat, dcn, bcn, ovl, hld);
      n_cmp++;
      if ({rb, rd} !== {eb[i], ed[i]}) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got diff=%0d bout=%b, want diff=%0d bout=%b",
                 i, rd, rb, ed[i], eb[i]);
      end
      n_cmp++;
      if (dat !== W || dcn !== 1) begin
        n_fail++;
        $display("FAIL directed_done[%0d]: got done at cycle %0d x%0d, want cycle %0d x1",
                 i, dat, dcn, W);
      end
      n_cmp++;
      if (bcn !== W) begin
        n_fail++;
        $display("FAIL directed_busy[%0d]: got busy for %0d cycles, want %0d", i, bcn, W);
      end
      n_cmp++;
      if (ovl !== 1'b0 || hld !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_status[%0d]: got overlap=%b held=%b, want 0 1", i, ovl, hld);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_ignore_start();
    int           dones;
    logic [W-1:0] rd;
    logic         rb;
    @(negedge clk);
    a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    a = 4'd1; b = 4'd8; start = 1'b1;   // lands on the second RUN edge
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0; rd = '0; rb = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) begin
        dones++; rd = diff; rb = bout;
      end
    end
    n_cmp++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL ignore_start_pulses: got %0d done pulses, want 1", dones);
    end
    n_cmp++;
    if ({rb, rd} !== {1'b0, 4'd5}) begin
      n_fail++;
      $display("FAIL ignore_start_result: got diff=%0d bout=%b, want diff=5 bout=0", rd, rb);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_run();
    logic [W-1:0] rd;
    logic         rb;
    int           dat, dcn, bcn, dones;
    bit           ovl, hld;
    do_op(4'd9, 4'd3, 1'b0, rd, rb, dat, dcn, bcn, ovl, hld);   // leaves diff=6
    n_cmp++;
    if (diff !== 4'd6) begin
      n_fail++;
      $display("FAIL rst_mid_setup: got diff=%0d, want 6", diff);
    end
    @(negedge clk);
    a = 4'd13; b = 4'd2; bin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_in_run: got busy=%b, want 1", busy);
    end
    rst = 1'b1;
    #1;   // well before the next rising edge
    n_cmp++;
    if ({diff, bout, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got diff=%0d bout=%b busy=%b done=%b, want all 0",
               diff, bout, busy, done);
    end
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_abandon: got %0d busy/done cycles after reset, want 0", dones);
    end
    do_op(4'd12, 4'd5, 1'b0, rd, rb, dat, dcn, bcn, ovl, hld);
    n_cmp++;
    if ({rb, rd} !== {1'b0, 4'd7} || dat !== W) begin
      n_fail++;
      $display("FAIL rst_mid_restart: got diff=%0d bout=%b at cycle %0d, want diff=7 bout=0 at %0d",
               rd, rb, dat, W);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_start_held();
    logic [W-1:0] ea, eb;
    logic         ebi;
    logic [W:0]   exp;
    int           prev, n, ovl;
    @(negedge clk);
    ea = W'($urandom); eb = W'($urandom); ebi = 1'($urandom);
    a = ea; b = eb; bin = ebi; start = 1'b1;
    prev = -1; n = 0; ovl = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy && done) ovl++;
      if (done) begin
        exp = model(int'(ea), int'(eb), int'(ebi));
        n_cmp++;
        if ({bout, diff} !== exp) begin
          n_fail++;
          $display("FAIL held_result[%0d]: got diff=%0d bout=%b, want diff=%0d bout=%b",
                   n, diff, bout, exp[W-1:0], exp[W]);
        end
        if (prev >= 0) begin
          n_cmp++;
          if (cyc - prev !== W + 2) begin
            n_fail++;
            $display("FAIL held_period[%0d]: got %0d cycles between results, want %0d",
                     n, cyc - prev, W + 2);
          end
        end
        prev = cyc; n++;
        // Next acceptance happens two edges from now, in IDLE.
        ea = W'($urandom); eb = W'($urandom); ebi = 1'($urandom);
        a = ea; b = eb; bin = ebi;
      end
    end
    start = 1'b0;
    for (int i = 0; i < W + 3; i++) @(negedge clk);
    n_cmp++;
    if (n !== 6 || ovl !== 0) begin
      n_fail++;
      $display("FAIL held_count: got %0d results (%0d overlaps) in 40 cycles, want 6 (0)", n, ovl);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_random();
    logic [W-1:0] oa, ob, rd;
    logic         obi, rb;
    logic [W:0]   exp;
    int           dat, dcn, bcn;
    bit           ovl, hld;
    for (int i = 0; i < 40; i++) begin
      oa = W'($urandom); ob = W'($urandom); obi = 1'($urandom);
      exp = model(int'(oa), int'(ob), int'(obi));
      do_op(oa, ob, obi, rd, rb, dat, dcn, bcn, ovl, hld);
      n_cmp++;
      if ({rb, rd} !== exp || dat !== W || dcn !== 1 || bcn !== W || ovl || !hld) begin
        n_fail++;
        $display("FAIL random[%0d] %0d-%0d-%0d: got diff=%0d bout=%b done@%0d x%0d busy=%0d ovl=%b held=%b, want diff=%0d bout=%b done@%0d x1 busy=%0d",
                 i, oa, ob, obi, rd, rb, dat, dcn, bcn, ovl, hld, exp[W-1:0], exp[W], W, W);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_exhaustive();
    logic [W-1:0] rd;
    logic         rb;
    logic [W:0]   exp;
    int           dat, dcn, bcn;
    bit           ovl, hld;
    for (int ia = 0; ia < (1 << W); ia++)
      for (int ib = 0; ib < (1 << W); ib++)
        for (int ic = 0; ic < 2; ic++) begin
          exp = model(ia, ib, ic);
          do_op(W'(ia), W'(ib), 1'(ic), rd, rb, dat, dcn, bcn, ovl, hld);
          n_cmp++;
          if ({rb, rd} !== exp || dcn !== 1) begin
            n_fail++;
            $display("FAIL exhaustive %0d-%0d-%0d: got diff=%0d bout=%b pulses=%0d, want diff=%0d bout=%b pulses=1",
                     ia, ib, ic, rd, rb, dcn, exp[W-1:0], exp[W]);
          end
        end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid_run();
    test_start_held();
    test_random();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
